wb_trace_buffer: RTL and testbench
==================================

# wb_trace_buffer

Retirement trace buffer sitting directly downstream of the CPU core's writeback debug port. It samples every register-file write (`debug_wb_pc`, `debug_wb_rf_wen`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`) into a circular buffer of the most recent writebacks. The captured entries are drained through a valid/ready readout port. Capture can optionally freeze a fixed number of entries after a PC trigger, so the history around a failing instruction survives for post-mortem readout.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `POST_TRIG`, 4, entries captured after the trigger entry before freezing; range 0..DEPTH-1.

- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `debug_wb_pc`  in  32  PC of the retiring instruction.
- `debug_wb_rf_wen`  in  4  writeback byte enables.
- `debug_wb_rf_wnum`  in  5  destination register.
- `debug_wb_rf_wdata`  in  32  writeback data.
- `clear`  in  1  synchronous flush: empties the buffer, zeroes `drop_cnt`, re-arms the trigger.
- `trig_en`  in  1  trigger enable.
- `trig_pc`  in  32  trigger PC.
- `rd_valid`  out  1  at least one entry is buffered.
- `rd_ready`  in  1  consumer accepts the head entry.
- `rd_pc`  out  32  head entry PC; 0 when `rd_valid`=0.
- `rd_wnum`  out  5  head entry register; 0 when `rd_valid`=0.
- `rd_wdata`  out  32  head entry data; 0 when `rd_valid`=0.
- `count`  out  log2(DEPTH)+1  entries held.
- `drop_cnt`  out  16  entries overwritten while full; saturates at 0xFFFF.
- `frozen`  out  1  capture halted after a trigger.

## Operation
- **Capture event:** `debug_wb_rf_wen != 0` and `debug_wb_rf_wnum != 0`, state not FROZEN, `clear` = 0. The event writes {pc, wnum, wdata} to `mem[wr_ptr]` and advances `wr_ptr` modulo DEPTH.
- **Pop:** `rd_valid && rd_ready`. Advances `rd_ptr`.
- **Head outputs:** combinational from `mem[rd_ptr]`, gated to 0 when `count` = 0.
- **Pointer/count rules by event mix:**
  - Push only, not full: `count` +1.
  - Push only, full: overwrite the oldest entry; `rd_ptr` and `wr_ptr` both advance; `count` stays DEPTH; `drop_cnt` +1 (saturating).
  - Push and pop together, any fill level: both pointers advance; `count` unchanged; no drop. The popped value is the pre-write head.
  - Pop only: `count` -1.
  - Pop when empty: impossible, since `rd_valid` = 0.
- **State machine:** states ARMED, POST, FROZEN. Reset and `clear` go to ARMED.
  - ARMED → POST: a capture event with `trig_en` = 1 and `debug_wb_pc == trig_pc`. The trigger entry itself is captured. The post-trigger counter loads POST_TRIG.
  - If POST_TRIG = 0, ARMED → FROZEN directly on the trigger.
  - POST: each capture decrements the counter. The capture that brings it to 0 is stored, and the state moves to FROZEN.
  - FROZEN: writebacks are ignored and not counted as drops. Pops continue.
  - `frozen` = 1 only in FROZEN.
- **Priority:** `rst` > `clear` > capture/pop. A `clear` cycle discards the same-cycle capture and pop.
- Reset or `clear` mid-operation discards all contents immediately; no partial drain.

## Timing
- Reset values: `rd_valid` 0, `rd_pc`/`rd_wnum`/`rd_wdata` 0, `count` 0, `drop_cnt` 0, `frozen` 0; state ARMED; both pointers 0.
- Capture latency: inputs are sampled at edge N. `count` and `rd_valid` reflect the entry after edge N, so 1 cycle.
- Pop takes effect at the edge where `rd_valid && rd_ready`. The next head is visible in the following cycle.
- `rd_valid` never depends combinationally on `rd_ready`.
- `frozen` rises in the cycle after the final post-trigger capture edge.
- Back-to-back captures every cycle are sustained indefinitely. When full, overwrite occurs every cycle with no bubble.

## Configuration
- Macro `WB_TRACE_TRIGGER_EN`.
- **Defined:** the ARMED/POST/FROZEN machine operates as specified.
- **Undefined:** the state is permanently ARMED. `trig_en` and `trig_pc` are accepted but ignored, `frozen` is tied 0, and the post-trigger counter is not built. All capture, overwrite and readout behaviour is unchanged.

## Test plan
- **Fill and drain:** DEPTH=16. Drive 5 writebacks (pc 0xBFC00000+4k, wnum k+1, wdata k) with `rd_ready`=0 → `count`=5. Then raise `rd_ready` → entries pop in order with pc 0xBFC00000, 0xBFC00004, …; `rd_valid` drops after 5 pops; `rd_pc`=0.
- **Filtering:** `wen`=0xF with `wnum`=0, and `wen`=0 with `wnum`=3 → `count` stays 0.
- **Overflow:** 20 captures with `rd_ready`=0 → `count`=16, `drop_cnt`=4, head pc = the 5th captured PC.
- **Simultaneous push/pop when full:** `count`=16, capture plus pop in the same cycle → popped entry is the old head, `count`=16, `drop_cnt` unchanged.
- **Trigger** (macro defined, POST_TRIG=4): `trig_pc`=0xBFC00020 hit at the 9th capture → exactly 4 more captures stored, `frozen`=1, later writebacks ignored, `drop_cnt`=0. `clear` then gives `count`=0, `frozen`=0.
- **Clear priority:** `clear` asserted with a capture and a pop in the same cycle → `count`=0, `drop_cnt`=0 next cycle.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// Circular trace of recent register-file writebacks with valid/ready drain.
// Optional PC trigger freeze is built when WB_TRACE_TRIGGER_EN is defined.
module wb_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_wen,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  input  logic                     clear,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [31:0]              rd_pc,
  output logic [4:0]               rd_wnum,
  output logic [31:0]              rd_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt,
  output logic                     frozen
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [15:0]   drop_q;

  logic hold;
  logic cap;
  logic pop;
  logic full;
  ent_t head;

  assign full = (count_q == CW'(DEPTH));
  assign cap  = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0)
              && !hold && !clear;
  assign pop  = rd_valid && rd_ready && !clear;

`ifdef WB_TRACE_TRIGGER_EN
  typedef enum logic [1:0] {ARMED, POST, FROZEN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] post_q, post_d;
  logic          hit;

  assign hit  = trig_en && (debug_wb_pc == trig_pc);
  assign hold = (state_q == FROZEN);

  // Trigger state and post-trigger countdown registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  // Arm on matching capture, count down post captures, then freeze.
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    unique case (state_q)
      ARMED: begin
        if (cap && hit) begin
          if (POST_TRIG == 0) begin
            state_d = FROZEN;
          end else begin
            state_d = POST;
            post_d  = AW'(POST_TRIG);
          end
        end
      end
      POST: begin
        if (cap) begin
          post_d = post_q - AW'(1);
          if (post_q == AW'(1)) state_d = FROZEN;
        end
      end
      FROZEN: begin
        state_d = FROZEN;
      end
      default: begin
        state_d = ARMED;
      end
    endcase
    if (clear) begin
      state_d = ARMED;
      post_d  = '0;
    end
  end

  assign frozen = hold;
`else
  logic unused_trig;
  assign unused_trig = ^{trig_en, trig_pc};
  assign hold        = 1'b0;
  assign frozen      = 1'b0;
`endif

  // Entry storage; written only by a capture, never reset.
  always_ff @(posedge clk) begin
    if (cap) begin
      mem_q[wr_ptr_q] <= '{pc: debug_wb_pc,
                           wnum: debug_wb_rf_wnum,
                           wdata: debug_wb_rf_wdata};
    end
  end

  // Pointers, occupancy and drop counter; overwrite oldest when full.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (cap) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop || (cap && full)) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (cap && full && !pop && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
      if (cap && !pop && !full) count_q <= count_q + CW'(1);
      else if (pop && !cap) count_q <= count_q - CW'(1);
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign rd_valid = (count_q != '0);
  assign rd_pc    = rd_valid ? head.pc    : 32'd0;
  assign rd_wnum  = rd_valid ? head.wnum  : 5'd0;
  assign rd_wdata = rd_valid ? head.wdata : 32'd0;
  assign count    = count_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed plus randomized bench for wb_trace_buffer against a queue model.
// Trigger expectations follow WB_TRACE_TRIGGER_EN as compiled.
module tb_wb_trace_buffer;

  localparam int DEPTH = 16;
  localparam int POST_TRIG = 4;
`ifdef WB_TRACE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        clear;
  logic        trig_en;
  logic [31:0] trig_pc;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_pc;
  logic [4:0]  rd_wnum;
  logic [31:0] rd_wdata;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
  logic        frozen;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .rst(rst),
    .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_wnum(rd_wnum), .rd_wdata(rd_wdata),
    .count(count), .drop_cnt(drop_cnt), .frozen(frozen)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  ent_t q[$];
  int   mdrop;
  int   mst;
  int   mrem;
  int   checks;
  int   failures;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head();
    bit v;
    v = (q.size() != 0);
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, v});
    chk("rd_pc", rd_pc, v ? q[0].pc : 32'd0);
    chk("rd_wnum", {27'd0, rd_wnum}, v ? {27'd0, q[0].wnum} : 32'd0);
    chk("rd_wdata", rd_wdata, v ? q[0].wdata : 32'd0);
  endtask

  task automatic check_state();
    chk("count", {27'd0, count}, q.size());
    chk("drop_cnt", {16'd0, drop_cnt}, mdrop);
    chk("frozen", {31'd0, frozen}, {31'd0, mst == 2});
  endtask

  task automatic cyc(input logic r, input logic c, input logic rdy,
                     input logic ten, input logic [31:0] pc,
                     input logic [3:0] wen, input logic [4:0] wn,
                     input logic [31:0] wd);
    bit pop, cap;
    ent_t e;
    rst = r; clear = c; rd_ready = rdy; trig_en = ten;
    debug_wb_pc = pc; debug_wb_rf_wen = wen;
    debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
    #1;
    check_head();
    @(posedge clk);
    #1;
    if (r || c) begin
      q.delete();
      mdrop = 0;
      mst = 0;
      mrem = 0;
    end else begin
      pop = rdy && q.size() != 0;
      cap = wen != 0 && wn != 0 && mst != 2;
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          if (mdrop < 65535) mdrop++;
        end
        e.pc = pc; e.wnum = wn; e.wdata = wd;
        q.push_back(e);
        if (TRIG && mst == 0 && ten && pc == trig_pc) begin
          mst = (POST_TRIG == 0) ? 2 : 1;
          mrem = POST_TRIG;
        end else if (mst == 1) begin
          mrem--;
          if (mrem == 0) mst = 2;
        end
      end
    end
    check_state();
  endtask

  task automatic wb(input logic rdy, input logic ten, input int k);
    cyc(0, 0, rdy, ten, 32'hBFC00000 + 32'(4 * k), 4'hF,
        5'(k + 1), 32'(k));
  endtask

  initial begin
    checks = 0; failures = 0;
    mdrop = 0; mst = 0; mrem = 0;
    trig_pc = 32'hBFC00020;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check_head();
    chk("reset_count", {27'd0, count}, 0);

    for (int k = 0; k < 5; k++) wb(0, 0, k);
    chk("fill_count", {27'd0, count}, 5);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("drained_pc", rd_pc, 0);

    cyc(0, 0, 0, 0, 32'h100, 4'hF, 5'd0, 32'h55);
    cyc(0, 0, 0, 0, 32'h104, 4'h0, 5'd3, 32'h66);
    chk("filter_count", {27'd0, count}, 0);

    for (int k = 0; k < 20; k++) wb(0, 0, k);
    check_head();
    chk("ovf_head", rd_pc, 32'hBFC00010);
    chk("ovf_drop", {16'd0, drop_cnt}, 4);
    wb(1, 0, 40);
    chk("pushpop_count", {27'd0, count}, 16);
    chk("pushpop_drop", {16'd0, drop_cnt}, 4);

    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) wb(0, 1, k);
    chk("trig_count", {27'd0, count}, TRIG ? 13 : 16);
    chk("trig_frozen", {31'd0, frozen}, {31'd0, TRIG});
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("clr_frozen", {31'd0, frozen}, 0);

    for (int k = 0; k < 3; k++) wb(0, 0, k);
    cyc(0, 1, 1, 0, 32'h200, 4'h3, 5'd7, 32'h77);
    chk("clrprio_count", {27'd0, count}, 0);
    chk("clrprio_drop", {16'd0, drop_cnt}, 0);

    for (int i = 0; i < 600; i++) begin
      cyc(0, ($urandom % 70) == 0, ($urandom % 3) == 0,
          ($urandom % 2) == 0,
          32'hBFC00000 + 32'(4 * ($urandom % 16)),
          (($urandom % 4) == 0) ? 4'h0 : 4'($urandom),
          5'($urandom), $urandom);
    end
    check_head();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
